fractal_fold_sdf: RTL
=====================

Name: fractal_fold_sdf

Overview:
- Parametrised successor to the team's single-shape Menger sponge SDF.
- Evaluates an iterated-fold box SDF (Menger-style fold, runtime-selectable iteration count) for one 3-D fixed-point point per request.
- Handshake is start/ready in, done pulse out. Sits between the ray marcher step controller and the distance compare.
- World scale is a power of two, so scaling and de-scaling are shifts and the block has no divider.

Parameters:
- BITS, 32, total signed fixed-point width.
- FIXED, 16, fractional bits.
- MAX_ITERS, 6, maximum fold iterations; fold scale ROM holds 3^k in fixed point for k = 0..MAX_ITERS-1.
- ITER_W, 3, width of iters input; must satisfy 2^ITER_W > MAX_ITERS.
- SCALE_SHIFT, 8, world scale = 2^SCALE_SHIFT.
- EPS, 33, surface bias in LSBs (0.0005 at Q16).

Ports:
- clk_in  in  1  clock.
- rst_n_in  in  1  asynchronous active-low reset.
- sdf_start  in  1  request; accepted only when sdf_ready=1.
- x, y, z  in  BITS  signed Qm.FIXED point.
- iters  in  ITER_W  fold count; values above MAX_ITERS are clamped to MAX_ITERS.
- sdf_ready  out  1  idle, can accept a request.
- sdf_done  out  1  one-cycle pulse; sdf_out is valid in the same cycle.
- sdf_out  out  BITS  signed distance; held until the next done pulse.

Behaviour:
- Reset (async assert, sync release): state=IDLE, sdf_ready=1, sdf_done=0, sdf_out=0, sqrt start=0.
- FSM states: IDLE -> LOAD -> FOLD (x n) -> BOXQ -> SQRT -> COMBINE -> DONE -> IDLE.
- IDLE:
  - On sdf_start: latch p = {x,y,z} <<< SCALE_SHIFT, latch n = min(iters, MAX_ITERS), k = n-1.
  - Drop sdf_ready the next cycle.
  - sdf_start while not ready is ignored; it is not queued.
- LOAD: one cycle. If n=0, go straight to BOXQ.
- FOLD: one cycle per iteration, scale s = ROM[k]. Per iteration:
  - p = s - abs(p), per axis.
  - If p.x > p.y, swap x and y.
  - Then if p.z > p.y, swap z and y.
  - p.y = abs(p.y - s/2) - s/2, where s/2 = s >>> 1.
  - Decrement k; exit to BOXQ after k=0.
- BOXQ: q = abs(p) - 0.5, per axis. Compute r = sum over axes of fmul(max(q,0), max(q,0)). Pulse sqrt start with rad = r.
- fmul(a,b) = (a*b) >>> FIXED, using a 2*BITS intermediate truncated to BITS.
- SQRT: use the codebase sqrt module (WIDTH=BITS, FBITS=FIXED; start/rad/root/valid). Wait for valid; latency is variable.
- COMBINE: d = root + min(max(q.x, q.y, q.z), 0). sdf_out = (d >>>SCALE_SHIFT) - EPS. Arithmetic shift, so it rounds toward -inf.
- DONE: sdf_done=1 for exactly one cycle. Next cycle: IDLE, sdf_ready=1.
- Latency from accepted start to done = n + 5 + sqrt latency.
- sdf_start asserted in the DONE cycle is ignored. The earliest back-to-back accept is the cycle after done.
- Reset mid-operation aborts immediately: no done pulse, and sdf_out returns to 0.
- All adds/subtracts wrap at BITS unless the optional feature is compiled in.

Optional Feature:
- Macro: SDF_SATURATE_EN.
- Defined: these operations saturate to the signed range of BITS (0x7FFF_FFFF / 0x8000_0000) instead of wrapping:
  - the input shift;
  - every fmul;
  - the r summation;
  - the final subtract.
- Undefined: plain two's-complement wrap, with smaller area.

Test Plan:
- iters=0, p=(0,0,0) -> done after 5+sqrt latency cycles; sdf_out = -128-33 = -161.
- iters=0, x=0x4000 (0.25), y=z=0 -> q.x=63.5, len=63.5; sdf_out = 16256-33 = 16223.
- iters=1, p=(0,0,0) -> folded p=(1,0,1), q=(0.5,-0.5,0.5), len≈46341; sdf_out = 181-33 = 148 (±1 LSB for sqrt rounding).
- iters=7 with MAX_ITERS=6 -> exactly 6 FOLD cycles and the same result as iters=6. sdf_start pulsed while busy -> ignored, exactly one done pulse.
- Reset asserted in the 3rd FOLD cycle -> sdf_ready=1 and sdf_out=0 immediately, no done pulse. A new request after release then completes correctly.
- SDF_SATURATE_EN defined, iters=0, x=0x10000 (1.0) -> r saturates to 0x7FFF_FFFF; sdf_out = 46308 ±2. Undefined: only a single done pulse is required.

Source files
------------

// File: rtl/fractal_fold_sdf.sv
// Iterated Menger-style fold box SDF for one fixed-point 3-D point per request.
// Optional build macro SDF_SATURATE_EN: saturating input shift, fmul, r summation and final subtract.
module fractal_fold_sdf #(
    parameter int BITS        = 32,
    parameter int FIXED       = 16,
    parameter int MAX_ITERS   = 6,
    parameter int ITER_W      = 3,
    parameter int SCALE_SHIFT = 8,
    parameter int EPS         = 33
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   sdf_start,
    input  logic signed [BITS-1:0] x,
    input  logic signed [BITS-1:0] y,
    input  logic signed [BITS-1:0] z,
    input  logic [ITER_W-1:0]      iters,
    output logic                   sdf_ready,
    output logic                   sdf_done,
    output logic signed [BITS-1:0] sdf_out
);

    localparam int WIDE      = 2 * BITS;
    localparam int ROM_DEPTH = 1 << ITER_W;
    localparam logic signed [BITS-1:0] HALF  = {{(BITS-FIXED){1'b0}}, 1'b1, {(FIXED-1){1'b0}}};
    localparam logic signed [BITS-1:0] EPS_V = BITS'(EPS);
    localparam logic [ITER_W-1:0]      MAX_N = ITER_W'(MAX_ITERS);
`ifdef SDF_SATURATE_EN
    localparam logic signed [WIDE-1:0] SAT_MAX = {{(BITS+1){1'b0}}, {(BITS-1){1'b1}}};
    localparam logic signed [WIDE-1:0] SAT_MIN = {{(BITS+1){1'b1}}, {(BITS-1){1'b0}}};
`endif

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FOLD,
        BOXQ,
        SQRT,
        COMBINE,
        DONE
    } state_t;

    state_t state, state_next;

    logic signed [BITS-1:0] p_x, p_y, p_z;
    logic [ITER_W-1:0]      n_iter, k_cnt, n_clamp;
    logic                   sqrt_start, sqrt_valid;
    logic [BITS-1:0]        sqrt_rad, sqrt_root;
    logic signed [BITS-1:0] root_r;

    function automatic logic signed [WIDE-1:0] ext(input logic signed [BITS-1:0] a);
        return {{BITS{a[BITS-1]}}, a};
    endfunction

    // Narrow a wide intermediate back to BITS: clamp or plain truncation.
    function automatic logic signed [BITS-1:0] fit(input logic signed [WIDE-1:0] v);
`ifdef SDF_SATURATE_EN
        if (v > SAT_MAX)
            return SAT_MAX[BITS-1:0];
        else if (v < SAT_MIN)
            return SAT_MIN[BITS-1:0];
        else
            return v[BITS-1:0];
`else
        return v[BITS-1:0];
`endif
    endfunction

    function automatic logic signed [BITS-1:0] sabs(input logic signed [BITS-1:0] a);
        return a[BITS-1] ? -a : a;
    endfunction

    function automatic logic signed [BITS-1:0] fmul(input logic signed [BITS-1:0] a,
                                                     input logic signed [BITS-1:0] b);
        logic signed [WIDE-1:0] prod;
        prod = ext(a) * ext(b);
        return fit(prod >>> FIXED);
    endfunction

    function automatic logic signed [BITS-1:0] pow3_fixed(input int k);
        logic signed [BITS-1:0] v;
        v = BITS'(1) <<< FIXED;
        for (int i = 0; i < k; i++)
            v = v + v + v;
        return v;
    endfunction

    logic signed [BITS-1:0] scale_rom [ROM_DEPTH];

    for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
        if (gi < MAX_ITERS) begin : g_used
            assign scale_rom[gi] = pow3_fixed(gi);
        end else begin : g_unused
            assign scale_rom[gi] = '0;
        end
    end

    assign n_clamp = (iters > MAX_N) ? MAX_N : iters;

    logic signed [BITS-1:0] in_x, in_y, in_z;
    assign in_x = fit(ext(x) <<< SCALE_SHIFT);
    assign in_y = fit(ext(y) <<< SCALE_SHIFT);
    assign in_z = fit(ext(z) <<< SCALE_SHIFT);

    // One fold iteration: reflect, sort so y holds the largest, then fold y about s/2.
    logic signed [BITS-1:0] s, h, fa_x, fa_y, fa_z;
    logic signed [BITS-1:0] sw_x, sw_y1, sw_y2, sw_z, fold_y;

    always_comb begin
        s     = scale_rom[k_cnt];
        h     = s >>> 1;
        fa_x  = s - sabs(p_x);
        fa_y  = s - sabs(p_y);
        fa_z  = s - sabs(p_z);
        sw_x  = fa_x;
        sw_y1 = fa_y;
        if (fa_x > fa_y) begin
            sw_x  = fa_y;
            sw_y1 = fa_x;
        end
        sw_z  = fa_z;
        sw_y2 = sw_y1;
        if (fa_z > sw_y1) begin
            sw_z  = sw_y1;
            sw_y2 = fa_z;
        end
        fold_y = sabs(sw_y2 - h) - h;
    end

    logic signed [BITS-1:0] q_x, q_y, q_z, m_x, m_y, m_z, r_sum;

    always_comb begin
        q_x   = sabs(p_x) - HALF;
        q_y   = sabs(p_y) - HALF;
        q_z   = sabs(p_z) - HALF;
        m_x   = q_x[BITS-1] ? '0 : q_x;
        m_y   = q_y[BITS-1] ? '0 : q_y;
        m_z   = q_z[BITS-1] ? '0 : q_z;
        r_sum = fit(ext(fit(ext(fmul(m_x, m_x)) + ext(fmul(m_y, m_y)))) + ext(fmul(m_z, m_z)));
    end

    // After BOXQ the p registers hold q, so COMBINE reads the interior term from them.
    logic signed [BITS-1:0] q_max, q_neg, d_val, out_next;

    always_comb begin
        q_max = p_x;
        if (p_y > q_max)
            q_max = p_y;
        if (p_z > q_max)
            q_max = p_z;
        q_neg    = q_max[BITS-1] ? q_max : '0;
        d_val    = root_r + q_neg;
        out_next = fit(ext(d_val >>> SCALE_SHIFT) - ext(EPS_V));
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        sdf_ready  = 1'b0;
        sdf_done   = 1'b0;
        case (state)
            IDLE: begin
                sdf_ready = 1'b1;
                if (sdf_start)
                    state_next = LOAD;
            end
            LOAD:    state_next = (n_iter == '0) ? BOXQ : FOLD;
            FOLD: begin
                if (k_cnt == '0)
                    state_next = BOXQ;
            end
            BOXQ:    state_next = SQRT;
            SQRT: begin
                if (sqrt_valid)
                    state_next = COMBINE;
            end
            COMBINE: state_next = DONE;
            DONE: begin
                sdf_done   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            p_x        <= '0;
            p_y        <= '0;
            p_z        <= '0;
            n_iter     <= '0;
            k_cnt      <= '0;
            sqrt_start <= 1'b0;
            sqrt_rad   <= '0;
            root_r     <= '0;
            sdf_out    <= '0;
        end else begin
            sqrt_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (sdf_start) begin
                        p_x    <= in_x;
                        p_y    <= in_y;
                        p_z    <= in_z;
                        n_iter <= n_clamp;
                        k_cnt  <= n_clamp - ITER_W'(1);
                    end
                end
                FOLD: begin
                    p_x   <= sw_x;
                    p_y   <= fold_y;
                    p_z   <= sw_z;
                    k_cnt <= k_cnt - ITER_W'(1);
                end
                BOXQ: begin
                    p_x        <= q_x;
                    p_y        <= q_y;
                    p_z        <= q_z;
                    sqrt_start <= 1'b1;
                    sqrt_rad   <= r_sum;
                end
                SQRT: begin
                    if (sqrt_valid)
                        root_r <= sqrt_root;
                end
                COMBINE: sdf_out <= out_next;
                default: ;
            endcase
        end
    end

    sqrt #(
        .WIDTH(BITS),
        .FBITS(FIXED)
    ) u_sqrt (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .start (sqrt_start),
        .rad   (sqrt_rad),
        .root  (sqrt_root),
        .valid (sqrt_valid)
    );

endmodule

// Fixed-point square root: root = floor(sqrt(rad << FBITS)), rad unsigned, digit-by-digit.
module sqrt #(
    parameter int WIDTH = 32,
    parameter int FBITS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] rad,
    output logic [WIDTH-1:0] root,
    output logic             valid
);

    localparam int RW    = WIDTH + FBITS;
    localparam int STEPS = RW / 2;
    localparam int RMW   = STEPS + 2;
    localparam int CW    = $clog2(STEPS + 1);

    logic             busy;
    logic [CW-1:0]    cnt;
    logic [RW-1:0]    src;
    logic [RMW-1:0]   rem, rem_sh, trial, rem_nx;
    logic [STEPS-1:0] res, res_nx;
    logic             ge;

    always_comb begin
        rem_sh = {rem[RMW-3:0], src[RW-1:RW-2]};
        trial  = {res, 2'b01};
        ge     = (rem_sh >= trial);
        rem_nx = ge ? (rem_sh - trial) : rem_sh;
        res_nx = {res[STEPS-2:0], ge};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            src   <= '0;
            rem   <= '0;
            res   <= '0;
            root  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start && !busy) begin
                busy <= 1'b1;
                cnt  <= CW'(STEPS);
                src  <= {rad, {FBITS{1'b0}}};
                rem  <= '0;
                res  <= '0;
            end else if (busy) begin
                src <= src << 2;
                rem <= rem_nx;
                res <= res_nx;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                    root  <= WIDTH'(res_nx);
                end
            end
        end
    end

endmodule
